// File: rtl/div_issue_hilo_pkg.sv
// div_pkg: shared constants and FSM state encoding for the divider issue
// front end (div_issue_hilo) and its HI/LO register file (hilo_regs).
package div_pkg;

   localparam int DATA_W       = 32;
   localparam int DRAIN_CYCLES = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_RELEASE = 2'd2,
      ST_DRAIN   = 2'd3
   } state_t;

endpackage

// File: rtl/div_issue_hilo_regs.sv
// hilo_regs: architectural HI/LO registers.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   commit                divider result write (wins over MTHI/MTLO)
//   commit_hi, commit_lo  remainder / quotient from the divider
//   hi_we, lo_we          MTHI / MTLO write enables
//   hi_wdata, lo_wdata    MTHI / MTLO data
//   hi, lo                registered HI / LO (no write-through)
module hilo_regs #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              commit,
   input  logic [DATA_W-1:0] commit_hi,
   input  logic [DATA_W-1:0] commit_lo,
   input  logic              hi_we,
   input  logic              lo_we,
   input  logic [DATA_W-1:0] hi_wdata,
   input  logic [DATA_W-1:0] lo_wdata,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   // The divide is younger than any MTHI/MTLO retiring in WB, so its
   // commit takes priority on a same-cycle collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi <= '0;
         lo <= '0;
      end else if (commit) begin
         hi <= commit_hi;
         lo <= commit_lo;
      end else begin
         if (hi_we) hi <= hi_wdata;
         if (lo_we) lo <= lo_wdata;
      end
   end

endmodule

// File: rtl/div_issue_hilo.sv
// div_issue_hilo: EX-stage front end for the multi-cycle divider.
// Latches DIV/DIVU operands, drives start/annul/signed to the divider,
// stalls the pipeline until the result returns and commits it to HI/LO.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ex_div_req_i, ex_signed_i      DIV/DIVU in EX, 1 = signed
//   ex_rs_i, ex_rt_i               dividend, divisor
//   flush_i                        kills the EX instruction
//   stall_o                        hold EX and earlier stages
//   div_start_o, div_annul_o       divider handshake
//   div_signed_o, div_op1_o/op2_o  latched operation
//   div_result_i, div_ready_i      {remainder, quotient}, result valid
//   hi_we_i/lo_we_i, *_wdata_i     MTHI / MTLO
//   hi_o, lo_o                     current HI / LO
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no divide outstanding; a request is latched and issued
// BUSY     | start held high, waiting for ready (or flush -> annul)
// RELEASE  | start low for one cycle after commit so the divider frees
// DRAIN    | start low for DRAIN_CYCLES after annul
module div_issue_hilo
   import div_pkg::*;
#(
   parameter int DATA_W = div_pkg::DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ex_div_req_i,
   input  logic                ex_signed_i,
   input  logic [DATA_W-1:0]   ex_rs_i,
   input  logic [DATA_W-1:0]   ex_rt_i,
   input  logic                flush_i,
   output logic                stall_o,
   output logic                div_start_o,
   output logic                div_annul_o,
   output logic                div_signed_o,
   output logic [DATA_W-1:0]   div_op1_o,
   output logic [DATA_W-1:0]   div_op2_o,
   input  logic [2*DATA_W-1:0] div_result_i,
   input  logic                div_ready_i,
   input  logic                hi_we_i,
   input  logic                lo_we_i,
   input  logic [DATA_W-1:0]   hi_wdata_i,
   input  logic [DATA_W-1:0]   lo_wdata_i,
   output logic [DATA_W-1:0]   hi_o,
   output logic [DATA_W-1:0]   lo_o
);

   localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYCLES - 1);

   state_t     state, state_nx;
   logic [1:0] drain_cnt;
   logic       issue;
   logic       commit;
   logic       req_live;

   assign req_live = ex_div_req_i & ~flush_i;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      stall_o     = 1'b0;
      div_annul_o = 1'b0;
      issue       = 1'b0;
      commit      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_live) begin
               issue    = 1'b1;
               stall_o  = 1'b1;
               state_nx = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // Flush outranks a same-cycle ready: the killed divide never commits.
            if (flush_i) begin
               div_annul_o = 1'b1;
               state_nx    = ST_DRAIN;
            end else if (div_ready_i) begin
               commit   = 1'b1;
               state_nx = ST_RELEASE;
            end else begin
               stall_o = 1'b1;
            end
         end
         ST_RELEASE: begin
            stall_o  = req_live;
            state_nx = ST_IDLE;
         end
         ST_DRAIN: begin
            stall_o = req_live;
            if (drain_cnt == 2'd0) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign div_start_o = (state == ST_BUSY);

   // Down-counter: loaded on annul, exits DRAIN at terminal count zero.
   always_ff @(posedge clk) begin
      if (rst)
         drain_cnt <= '0;
      else if (div_annul_o)
         drain_cnt <= DRAIN_LOAD;
      else if (state == ST_DRAIN && drain_cnt != 2'd0)
         drain_cnt <= drain_cnt - 2'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_op1_o    <= '0;
         div_op2_o    <= '0;
         div_signed_o <= 1'b0;
      end else if (issue) begin
         div_op1_o    <= ex_rs_i;
         div_op2_o    <= ex_rt_i;
         div_signed_o <= ex_signed_i;
      end
   end

   hilo_regs #(.DATA_W(DATA_W)) u_hilo (
      .clk       (clk),
      .rst       (rst),
      .commit    (commit),
      .commit_hi (div_result_i[2*DATA_W-1:DATA_W]),
      .commit_lo (div_result_i[DATA_W-1:0]),
      .hi_we     (hi_we_i),
      .lo_we     (lo_we_i),
      .hi_wdata  (hi_wdata_i),
      .lo_wdata  (lo_wdata_i),
      .hi        (hi_o),
      .lo        (lo_o)
   );

endmodule

// File: tb/tb_div_issue_hilo.sv
module tb_div_issue_hilo;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_div_req_i, ex_signed_i, flush_i;
   logic [31:0] ex_rs_i, ex_rt_i;
   logic        stall_o, div_start_o, div_annul_o, div_signed_o;
   logic [31:0] div_op1_o, div_op2_o;
   logic [63:0] div_result_i;
   logic        div_ready_i;
   logic        hi_we_i, lo_we_i;
   logic [31:0] hi_wdata_i, lo_wdata_i, hi_o, lo_o;

   int errors = 0;
   int checks = 0;
   logic [63:0] sb[$];

   always #5 clk = ~clk;

   div_issue_hilo #(.DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .ex_div_req_i(ex_div_req_i), .ex_signed_i(ex_signed_i),
      .ex_rs_i(ex_rs_i), .ex_rt_i(ex_rt_i), .flush_i(flush_i),
      .stall_o(stall_o), .div_start_o(div_start_o), .div_annul_o(div_annul_o),
      .div_signed_o(div_signed_o), .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
      .div_result_i(div_result_i), .div_ready_i(div_ready_i),
      .hi_we_i(hi_we_i), .lo_we_i(lo_we_i),
      .hi_wdata_i(hi_wdata_i), .lo_wdata_i(lo_wdata_i),
      .hi_o(hi_o), .lo_o(lo_o)
   );

   // Divider stand-in: ready 35 cycles into start (3 for divisor zero),
   // held until start drops.
   logic [5:0] dv_cnt, dv_lat;
   assign dv_lat      = (div_op2_o == 32'd0) ? 6'd3 : 6'd35;
   assign div_ready_i = div_start_o && (dv_cnt == dv_lat);

   always_ff @(posedge clk) begin
      if (rst || !div_start_o) dv_cnt <= '0;
      else if (dv_cnt != dv_lat) dv_cnt <= dv_cnt + 6'd1;
   end

   always_comb begin
      div_result_i = '0;
      if (div_op2_o != 32'd0) begin
         if (div_signed_o)
            div_result_i = {32'($signed(div_op1_o) % $signed(div_op2_o)),
                            32'($signed(div_op1_o) / $signed(div_op2_o))};
         else
            div_result_i = {div_op1_o % div_op2_o, div_op1_o / div_op2_o};
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: a commit cycle is start & ready & !flush; HI/LO are compared
   // with the oldest expected entry just after that edge.
   always @(negedge clk) begin
      if (!rst && div_start_o && div_ready_i && !flush_i) begin
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL commit_unexpected: got hi=%0h lo=%0h expected no commit", hi_o, lo_o);
         end else begin
            logic [63:0] e;
            e = sb.pop_front();
            chk("commit_hilo", {hi_o, lo_o}, e);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Called just after a posedge (cycle 0). Returns at the negedge of the
   // first cycle with stall low, request still asserted.
   task automatic run_div(input logic sgn, input logic [31:0] rs, input logic [31:0] rt,
                          input logic push, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic mthi, input logic [31:0] mthi_v,
                          output int stall_n, output int start_off);
      bit done;
      if (push) sb.push_back({ehi, elo});
      ex_signed_i  = sgn;
      ex_rs_i      = rs;
      ex_rt_i      = rt;
      ex_div_req_i = 1'b1;
      stall_n   = 0;
      start_off = -1;
      done      = 0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (div_start_o && start_off < 0) start_off = c;
         if (!stall_o) begin
            done = 1;
            if (mthi) begin
               hi_we_i    = 1'b1;
               hi_wdata_i = mthi_v;
            end
         end else begin
            stall_n++;
            tick();
         end
      end
      if (!done) chk("div_timeout", 64'(stall_n), 64'd0);
   endtask

   task automatic retire;
      tick();
      ex_div_req_i = 1'b0;
      hi_we_i      = 1'b0;
      tick();
   endtask

   int sn, so;

   initial begin
      rst = 1'b1;
      ex_div_req_i = 0; ex_signed_i = 0; flush_i = 0;
      ex_rs_i = 0; ex_rt_i = 0;
      hi_we_i = 0; lo_we_i = 0; hi_wdata_i = 0; lo_wdata_i = 0;
      repeat (2) tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_hi", 64'(hi_o), 64'd0);
      chk("rst_lo", 64'(lo_o), 64'd0);
      chk("rst_ops", {div_op1_o, div_op2_o}, 64'd0);
      chk("rst_ctl", {60'd0, div_signed_o, div_start_o, div_annul_o, stall_o}, 64'd0);
      tick();

      // DIVU 100 / 7
      run_div(1'b0, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0, 32'd0, sn, so);
      chk("divu100_stall", 64'(sn), 64'd36);
      chk("divu100_start", 64'(so), 64'd1);
      tick();
      ex_div_req_i = 1'b0;
      @(negedge clk);
      chk("release_start_low", 64'(div_start_o), 64'd0);
      tick();

      // DIV -7 / 2
      run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32'd0, sn, so);
      chk("div_neg_signed", 64'(div_signed_o), 64'd1);
      retire();

      // DIVU 0xFFFFFFF9 / 2
      run_div(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'd1, 32'h7FFF_FFFC, 1'b0, 32'd0, sn, so);
      retire();

      // Flush in cycle 10 of 100 / 7, new DIV 9 / 3 arrives during DRAIN
      ex_signed_i = 0; ex_rs_i = 32'd100; ex_rt_i = 32'd7; ex_div_req_i = 1'b1;
      repeat (10) tick();
      flush_i = 1'b1;
      @(negedge clk);
      chk("flush_annul", 64'(div_annul_o), 64'd1);
      chk("flush_stall", 64'(stall_o), 64'd0);
      tick();
      flush_i = 1'b0;
      chk("flush_keep_hilo", {hi_o, lo_o}, {32'd1, 32'h7FFF_FFFC});
      chk("drain_start_low", 64'(div_start_o), 64'd0);
      run_div(1'b1, 32'd9, 32'd3, 1'b1, 32'd0, 32'd3, 1'b0, 32'd0, sn, so);
      chk("drain_issue_start", 64'(so), 64'd3);
      chk("drain_issue_stall", 64'(sn), 64'd38);
      retire();

      // DIV 5 / 0 flushed in the same cycle ready rises: no commit
      ex_signed_i = 1; ex_rs_i = 32'd5; ex_rt_i = 32'd0; ex_div_req_i = 1'b1;
      repeat (4) tick();
      flush_i = 1'b1;
      @(negedge clk);
      chk("flush_ready_annul", {62'd0, div_annul_o, div_ready_i}, 64'd3);
      tick();
      flush_i = 1'b0;
      ex_div_req_i = 1'b0;
      chk("flush_ready_keep", {hi_o, lo_o}, {32'd0, 32'd3});
      repeat (3) tick();

      // DIV 5 / 0
      run_div(1'b1, 32'd5, 32'd0, 1'b1, 32'd0, 32'd0, 1'b0, 32'd0, sn, so);
      chk("div0_stall", 64'(sn), 64'd4);
      retire();

      // MTHI collides with the 100 / 7 commit, MTLO the cycle after
      run_div(1'b0, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b1, 32'h0000_AAAA, sn, so);
      tick();
      ex_div_req_i = 1'b0;
      hi_we_i      = 1'b0;
      lo_we_i      = 1'b1;
      lo_wdata_i   = 32'h55;
      tick();
      lo_we_i = 1'b0;
      chk("mtlo_after", {hi_o, lo_o}, {32'd2, 32'h55});
      tick();

      // Back-to-back DIVU 10 / 3 then 20 / 6
      run_div(1'b0, 32'd10, 32'd3, 1'b1, 32'd1, 32'd3, 1'b0, 32'd0, sn, so);
      tick();
      run_div(1'b0, 32'd20, 32'd6, 1'b1, 32'd2, 32'd3, 1'b0, 32'd0, sn, so);
      chk("b2b_start", 64'(so), 64'd2);
      chk("b2b_stall", 64'(sn), 64'd37);
      retire();
      chk("b2b_final", {hi_o, lo_o}, {32'd2, 32'd3});

      // Reset mid-operation
      ex_signed_i = 0; ex_rs_i = 32'd100; ex_rt_i = 32'd7; ex_div_req_i = 1'b1;
      repeat (5) tick();
      rst = 1'b1;
      ex_div_req_i = 1'b0;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_start", 64'(div_start_o), 64'd0);
      chk("midrst_hilo", {hi_o, lo_o}, 64'd0);
      tick();

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
